hog_axil_slave_regs: RTL

AXI4-Lite GP responder holding the HOG accelerator's control and configuration registers. The UVM GP agent drives it as initiator over the 5-bit address, 32-bit data GP port. It decodes register writes and reads, and presents configuration plus a one-cycle start pulse to the HOG core. It also reflects the core's ready/busy status back to software.

---
 rtl/hog_axil_pkg.sv | 35 +++
 rtl/hog_axil_wr_join.sv | 80 ++++++++
 rtl/hog_axil_slave_regs.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hog_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hog_axil_pkg
// Brief    : Register map, STATUS bit positions and response codes shared by
//            the HOG AXI4-Lite register block.
// Revision : 1.0
// ============================================================================
package hog_axil_pkg;

    localparam logic [4:0] c_OFF_CTRL        = 5'h00;
    localparam logic [4:0] c_OFF_STATUS      = 5'h04;
    localparam logic [4:0] c_OFF_WIDTH       = 5'h08;
    localparam logic [4:0] c_OFF_HEIGHT      = 5'h0C;
    localparam logic [4:0] c_OFF_BRAM_HEIGHT = 5'h10;

    localparam int c_STAT_READY = 0;
    localparam int c_STAT_BUSY  = 1;
    localparam int c_STAT_ERR   = 2;

    localparam logic [1:0] c_RESP_OKAY = 2'b00;

    // Merge the byte lanes selected by strb from new_val into old_val.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] w_merged;
        w_merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) w_merged[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return w_merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hog_axil_wr_join.sv
`default_nettype none
// ============================================================================
// Module   : hog_axil_wr_join
// Brief    : Joins independently accepted AW and W beats into one commit
//            strobe and owns the single-outstanding B response.
// Revision : 1.0
// ============================================================================
module hog_axil_wr_join #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic                    o_commit,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [DATA_WIDTH/8-1:0] o_strb
);

    logic                    r_aw_valid;
    logic [ADDR_WIDTH-1:0]   r_aw_addr;
    logic                    r_w_valid;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [DATA_WIDTH/8-1:0] r_w_strb;
    logic                    r_bvalid;
    logic                    w_aw_hs;
    logic                    w_w_hs;

    assign o_awready = ~rst & ~r_aw_valid & ~r_bvalid;
    assign o_wready  = ~rst & ~r_w_valid  & ~r_bvalid;
    assign w_aw_hs   = i_awvalid & o_awready;
    assign w_w_hs    = i_wvalid  & o_wready;
    assign o_bvalid  = r_bvalid;

    // Commit fires in the cycle the second half of the pair arrives, so a
    // beat accepted this cycle is forwarded straight from the bus.
    assign o_commit = (r_aw_valid | w_aw_hs) & (r_w_valid | w_w_hs) & ~r_bvalid;
    assign o_addr   = r_aw_valid ? r_aw_addr : i_awaddr;
    assign o_data   = r_w_valid  ? r_w_data  : i_wdata;
    assign o_strb   = r_w_valid  ? r_w_strb  : i_wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_valid <= 1'b0;
            r_aw_addr  <= '0;
            r_w_valid  <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_valid <= 1'b1;
                r_aw_addr  <= i_awaddr;
            end
            if (w_w_hs) begin
                r_w_valid <= 1'b1;
                r_w_data  <= i_wdata;
                r_w_strb  <= i_wstrb;
            end
            if (o_commit) begin
                r_bvalid <= 1'b1;
            end else if (r_bvalid & i_bready) begin
                r_bvalid   <= 1'b0;
                r_aw_valid <= 1'b0;
                r_w_valid  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hog_axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : hog_axil_slave_regs
// Brief    : AXI4-Lite control/status register block for the HOG core:
//            image dimensions, start pulse and busy/error status.
// Revision : 1.0
// ============================================================================
module hog_axil_slave_regs
    import hog_axil_pkg::*;
#(
    parameter int C_S_AXI_GP_DATA_WIDTH = 32,
    parameter int C_S_AXI_GP_ADDR_WIDTH = 5,
    parameter int DIM_WIDTH             = 11
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                         s_axi_awprot,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [C_S_AXI_GP_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_GP_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [1:0]                         s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                         s_axi_arprot,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [C_S_AXI_GP_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    output logic                               start_o,
    input  logic                               ready_i,
    output logic [DIM_WIDTH-1:0]               width_o,
    output logic [DIM_WIDTH-1:0]               height_o,
    output logic [DIM_WIDTH-1:0]               bram_height_o
);

    localparam int c_PAD = C_S_AXI_GP_DATA_WIDTH - DIM_WIDTH;

    logic                               w_commit;
    logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   w_waddr;
    logic [C_S_AXI_GP_DATA_WIDTH-1:0]   w_wdata;
    logic [C_S_AXI_GP_DATA_WIDTH/8-1:0] w_wstrb;
    logic [2:0]                         w_wr_idx;
    logic                               w_start_req;
    logic                               w_err_clr;
    logic [C_S_AXI_GP_DATA_WIDTH-1:0]   w_width_nx;
    logic [C_S_AXI_GP_DATA_WIDTH-1:0]   w_height_nx;
    logic [C_S_AXI_GP_DATA_WIDTH-1:0]   w_bram_nx;
    logic [C_S_AXI_GP_DATA_WIDTH-1:0]   w_status;
    logic [C_S_AXI_GP_DATA_WIDTH-1:0]   w_rd_data;
    logic                               w_ar_hs;
    logic                               w_unused;

    logic [DIM_WIDTH-1:0]               r_width;
    logic [DIM_WIDTH-1:0]               r_height;
    logic [DIM_WIDTH-1:0]               r_bram_height;
    logic                               r_start;
    logic                               r_busy;
    logic                               r_err;
    logic                               r_rvalid;
    logic [C_S_AXI_GP_DATA_WIDTH-1:0]   r_rdata;

    hog_axil_wr_join #(
        .ADDR_WIDTH (C_S_AXI_GP_ADDR_WIDTH),
        .DATA_WIDTH (C_S_AXI_GP_DATA_WIDTH)
    ) u_wr_join (
        .clk       (clk),
        .rst       (rst),
        .i_awaddr  (s_axi_awaddr),
        .i_awvalid (s_axi_awvalid),
        .o_awready (s_axi_awready),
        .i_wdata   (s_axi_wdata),
        .i_wstrb   (s_axi_wstrb),
        .i_wvalid  (s_axi_wvalid),
        .o_wready  (s_axi_wready),
        .o_bvalid  (s_axi_bvalid),
        .i_bready  (s_axi_bready),
        .o_commit  (w_commit),
        .o_addr    (w_waddr),
        .o_data    (w_wdata),
        .o_strb    (w_wstrb)
    );

    assign s_axi_bresp = c_RESP_OKAY;
    assign s_axi_rresp = c_RESP_OKAY;

    assign w_wr_idx    = w_waddr[4:2];
    assign w_start_req = w_commit & (w_wr_idx == c_OFF_CTRL[4:2]) & w_wstrb[0] & w_wdata[0];
    assign w_err_clr   = w_commit & (w_wr_idx == c_OFF_STATUS[4:2])
                         & w_wstrb[0] & w_wdata[c_STAT_ERR];

    assign w_width_nx  = apply_wstrb({{c_PAD{1'b0}}, r_width},       w_wdata, w_wstrb);
    assign w_height_nx = apply_wstrb({{c_PAD{1'b0}}, r_height},      w_wdata, w_wstrb);
    assign w_bram_nx   = apply_wstrb({{c_PAD{1'b0}}, r_bram_height}, w_wdata, w_wstrb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width       <= '0;
            r_height      <= '0;
            r_bram_height <= '0;
        end else if (w_commit) begin
            if (w_wr_idx == c_OFF_WIDTH[4:2])       r_width       <= w_width_nx[DIM_WIDTH-1:0];
            if (w_wr_idx == c_OFF_HEIGHT[4:2])      r_height      <= w_height_nx[DIM_WIDTH-1:0];
            if (w_wr_idx == c_OFF_BRAM_HEIGHT[4:2]) r_bram_height <= w_bram_nx[DIM_WIDTH-1:0];
        end
    end

    // busy may only drop on a ready seen after the pulse cycle, so a core
    // that is still idle when start arrives is not mistaken for done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_start <= w_start_req & ~r_busy;
            if (w_start_req & ~r_busy) begin
                r_busy <= 1'b1;
            end else if (r_busy & ~r_start & ready_i) begin
                r_busy <= 1'b0;
            end
            if (w_start_req & r_busy) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status               = '0;
        w_status[c_STAT_READY] = ready_i;
        w_status[c_STAT_BUSY]  = r_busy;
        w_status[c_STAT_ERR]   = r_err;
    end

    always_comb begin
        w_rd_data = '0;
        case (s_axi_araddr[4:2])
            c_OFF_STATUS[4:2]:      w_rd_data = w_status;
            c_OFF_WIDTH[4:2]:       w_rd_data = {{c_PAD{1'b0}}, r_width};
            c_OFF_HEIGHT[4:2]:      w_rd_data = {{c_PAD{1'b0}}, r_height};
            c_OFF_BRAM_HEIGHT[4:2]: w_rd_data = {{c_PAD{1'b0}}, r_bram_height};
            default:                w_rd_data = '0;
        endcase
    end

    assign s_axi_arready = ~rst & ~r_rvalid;
    assign w_ar_hs       = s_axi_arvalid & s_axi_arready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
        end else if (r_rvalid & s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign start_o       = r_start;
    assign width_o       = r_width;
    assign height_o      = r_height;
    assign bram_height_o = r_bram_height;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot, w_waddr[1:0], s_axi_araddr[1:0],
                        w_width_nx[C_S_AXI_GP_DATA_WIDTH-1:DIM_WIDTH],
                        w_height_nx[C_S_AXI_GP_DATA_WIDTH-1:DIM_WIDTH],
                        w_bram_nx[C_S_AXI_GP_DATA_WIDTH-1:DIM_WIDTH]};

endmodule
`default_nettype wire
